// File: rtl/pq_cmd_adapter.sv
// Valid/ready front-end for the systolic min-priority queue: turns push/pop requests
// into single-cycle enqueue/dequeue/replace pulses, then waits out the queue's settle time.
module pq_cmd_adapter #(
    parameter int QUEUE_SIZE    = 4,
    parameter int DATA_WIDTH    = 16,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                  i_CLK,
    input  logic                  i_RSTn,
    input  logic                  i_push_valid,
    output logic                  o_push_ready,
    input  logic [DATA_WIDTH-1:0] i_push_data,
    input  logic                  i_pop_valid,
    output logic                  o_pop_ready,
    output logic                  o_rsp_valid,
    input  logic                  i_rsp_ready,
    output logic [DATA_WIDTH-1:0] o_rsp_data,
    output logic                  o_q_wrt,
    output logic                  o_q_read,
    output logic [DATA_WIDTH-1:0] o_q_data,
    input  logic                  i_q_full,
    input  logic                  i_q_empty,
    input  logic [DATA_WIDTH-1:0] i_q_head
);

    localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ISSUE  = 2'd1;
    localparam logic [1:0] SETTLE = 2'd2;

    if (SETTLE_CYCLES < 1) begin : gSettleCheck
        $error("pq_cmd_adapter: SETTLE_CYCLES must be at least 1");
    end
    if (QUEUE_SIZE < 1) begin : gSizeCheck
        $error("pq_cmd_adapter: QUEUE_SIZE must be at least 1");
    end

    logic [1:0]            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  qWrt_q, qRead_q;
    logic [DATA_WIDTH-1:0] qData_q;
    logic                  rspValid_q;
    logic [DATA_WIDTH-1:0] rspData_q;
    logic                  popReady, pushReady, pushFire, popFire;

    // A pop needs a free response slot and a non-empty queue; a full queue can
    // still take a push if it is paired with a pop into a replace.
    assign popReady  = (state_q == IDLE) && !i_q_empty && !rspValid_q;
    assign pushReady = (state_q == IDLE) && (!i_q_full || (i_pop_valid && popReady));
    assign pushFire  = i_push_valid && pushReady;
    assign popFire   = i_pop_valid && popReady;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (pushFire || popFire) state_d = ISSUE;
            end
            ISSUE: begin
                state_d = SETTLE;
                cnt_d   = CNT_LOAD;
            end
            SETTLE: begin
                if (cnt_q == '0) state_d = IDLE;
                else             cnt_d   = cnt_q - 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    // Issue bits are only set on an accept edge, so they are high for the ISSUE cycle alone.
    always_ff @(posedge i_CLK or negedge i_RSTn) begin
        if (!i_RSTn) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            qWrt_q     <= 1'b0;
            qRead_q    <= 1'b0;
            qData_q    <= '0;
            rspValid_q <= 1'b0;
            rspData_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            qWrt_q  <= pushFire;
            qRead_q <= popFire;
            if (pushFire) qData_q <= i_push_data;
            if (popFire) begin
                rspValid_q <= 1'b1;
                rspData_q  <= i_q_head;
            end else if (rspValid_q && i_rsp_ready) begin
                rspValid_q <= 1'b0;
            end
        end
    end

    assign o_push_ready = pushReady;
    assign o_pop_ready  = popReady;
    assign o_q_wrt      = qWrt_q;
    assign o_q_read     = qRead_q;
    assign o_q_data     = qData_q;
    assign o_rsp_valid  = rspValid_q;
    assign o_rsp_data   = rspData_q;

endmodule

// File: tb/tb_pq_cmd_adapter.sv
// Randomized bench for pq_cmd_adapter: a sorted-queue model stands in for the downstream
// queue and predicts readiness, issue pulses and popped minima cycle by cycle.
`timescale 1ns/1ps
module tb_pq_cmd_adapter;

    localparam int DW = 16;
    localparam int SC = 2;
    localparam int QS = 4;

    logic          clk = 1'b0;
    logic          rstn;
    logic          pushValid, popValid, rspReady;
    logic [DW-1:0] pushData;
    logic          pushReady, popReady, rspValid, qWrt, qRead;
    logic [DW-1:0] rspData, qData;
    logic          qFull, qEmpty;
    logic [DW-1:0] qHead;

    int vectors     = 0;
    int miscompares = 0;

    // Behavioural model: sorted contents of the queue plus expected adapter outputs.
    logic [DW-1:0] pq[$];
    int            busy;
    logic          mRspValid, mWrt, mRead;
    logic [DW-1:0] mRspData, mQData;

    pq_cmd_adapter #(.QUEUE_SIZE(QS), .DATA_WIDTH(DW), .SETTLE_CYCLES(SC)) dut (
        .i_CLK(clk), .i_RSTn(rstn),
        .i_push_valid(pushValid), .o_push_ready(pushReady), .i_push_data(pushData),
        .i_pop_valid(popValid), .o_pop_ready(popReady),
        .o_rsp_valid(rspValid), .i_rsp_ready(rspReady), .o_rsp_data(rspData),
        .o_q_wrt(qWrt), .o_q_read(qRead), .o_q_data(qData),
        .i_q_full(qFull), .i_q_empty(qEmpty), .i_q_head(qHead)
    );

    always #10 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void insertSorted(input logic [DW-1:0] v);
        int i = 0;
        while (i < pq.size() && pq[i] <= v) i++;
        pq.insert(i, v);
    endfunction

    task automatic driveQueueFlags();
        qFull  = (pq.size() == QS);
        qEmpty = (pq.size() == 0);
        qHead  = (pq.size() == 0) ? '0 : pq[0];
    endtask

    task automatic resetModel();
        pq.delete();
        busy      = 0;
        mRspValid = 1'b0;
        mWrt      = 1'b0;
        mRead     = 1'b0;
        mRspData  = '0;
        mQData    = '0;
    endtask

    // One clock cycle: check registered outputs, drive random requests, check readiness,
    // then advance the model across the coming edge.
    task automatic applyStimulus(input int pushPct, input int popPct, input int rdyPct);
        logic idle, expPopReady, expPushReady, pushFire, popFire;
        @(negedge clk);
        checkOutput("q_wrt", 32'(qWrt), 32'(mWrt));
        checkOutput("q_read", 32'(qRead), 32'(mRead));
        checkOutput("q_data", 32'(qData), 32'(mQData));
        checkOutput("rsp_valid", 32'(rspValid), 32'(mRspValid));
        checkOutput("rsp_data", 32'(rspData), 32'(mRspData));
        pushValid = ($urandom_range(99) < pushPct);
        popValid  = ($urandom_range(99) < popPct);
        rspReady  = ($urandom_range(99) < rdyPct);
        pushData  = DW'($urandom);
        driveQueueFlags();
        #1;
        idle         = (busy == 0);
        expPopReady  = idle && (pq.size() != 0) && !mRspValid;
        expPushReady = idle && ((pq.size() != QS) || (popValid && expPopReady));
        checkOutput("push_ready", 32'(pushReady), 32'(expPushReady));
        checkOutput("pop_ready", 32'(popReady), 32'(expPopReady));
        pushFire = pushValid && expPushReady;
        popFire  = popValid && expPopReady;
        if (mRspValid && rspReady) mRspValid = 1'b0;
        if (popFire) begin
            mRspValid = 1'b1;
            mRspData  = pq.pop_front();
        end
        if (pushFire) begin
            mQData = pushData;
            insertSorted(pushData);
        end
        mWrt  = pushFire;
        mRead = popFire;
        if (pushFire || popFire) busy = 1 + SC;
        else if (busy > 0)       busy = busy - 1;
    endtask

    initial begin
        rstn      = 1'b0;
        pushValid = 1'b0;
        popValid  = 1'b0;
        rspReady  = 1'b0;
        pushData  = '0;
        resetModel();
        driveQueueFlags();
        #3;
        checkOutput("reset push_ready", 32'(pushReady), 32'd1);
        checkOutput("reset pop_ready", 32'(popReady), 32'd0);
        checkOutput("reset q_wrt", 32'(qWrt), 32'd0);
        checkOutput("reset q_read", 32'(qRead), 32'd0);
        checkOutput("reset rsp_valid", 32'(rspValid), 32'd0);
        checkOutput("reset rsp_data", 32'(rspData), 32'd0);
        @(negedge clk);
        rstn = 1'b1;

        // Force a push, then drop reset into the middle of its settle window.
        applyStimulus(100, 0, 100);
        applyStimulus(0, 0, 100);
        applyStimulus(0, 0, 100);
        #2;
        rstn = 1'b0;
        resetModel();
        driveQueueFlags();
        #1;
        checkOutput("async q_wrt", 32'(qWrt), 32'd0);
        checkOutput("async q_read", 32'(qRead), 32'd0);
        checkOutput("async q_data", 32'(qData), 32'd0);
        checkOutput("async rsp_valid", 32'(rspValid), 32'd0);
        checkOutput("async push_ready", 32'(pushReady), 32'd1);
        checkOutput("async pop_ready", 32'(popReady), 32'd0);
        #1;
        rstn = 1'b1;

        for (int i = 0; i < 300; i++) applyStimulus(80, 30, 70);
        for (int i = 0; i < 300; i++) applyStimulus(30, 80, 60);
        for (int i = 0; i < 300; i++) applyStimulus(60, 60, 30);
        for (int i = 0; i < 100; i++) applyStimulus(95, 95, 20);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
